// File: rtl/mem_port_arbiter.sv
// Shares one cmd/rsp memory port between instruction fetch and data access,
// serialising each transaction into 34-bit command words and returning the response or a timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        cmd_stb,
    output logic [33:0] cmd_word,
    input  logic        cmd_busy,
    input  logic        rsp_stb,
    input  logic [33:0] rsp_word
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]    TMO_LOAD   = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD_CMD, WR_ADR, WR_DAT, WAIT_RSP, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          gnt_if_q, gnt_if_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          cmd_stb_q, cmd_stb_d;
    logic [33:0]   cmd_word_q, cmd_word_d;
    logic          if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic          if_err_q, if_err_d, d_err_q, d_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

    logic          fetch_wins;
    logic          done_fire;
    logic [31:0]   done_data;
    logic          done_err;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_if_d   = gnt_if_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_err_d   = if_err_q;
        d_err_d    = d_err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        done_fire  = 1'b0;
        done_data  = 32'h0;
        done_err   = 1'b0;

        // Data normally wins; a waiting fetch wins once data has had STARVE_MAX grants in a row.
        fetch_wins = if_req && (!d_req || (starve_q == STARVE_LIM));

        unique case (state_q)
            IDLE: begin
                if (!if_req) starve_d = '0;
                if (fetch_wins) begin
                    gnt_if_d = 1'b1;
                    addr_d   = if_addr;
                    starve_d = '0;
                    state_d  = RD_CMD;
                end else if (d_req) begin
                    gnt_if_d = 1'b0;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    if (if_req) starve_d = starve_q + SW'(1);
                    state_d  = d_we ? WR_ADR : RD_CMD;
                end
            end
            RD_CMD: begin
                if (!cmd_busy) begin
                    state_d = WAIT_RSP;
                    tmo_d   = TMO_LOAD;
                end
            end
            WR_ADR: begin
                if (!cmd_busy) state_d = WR_DAT;
            end
            WR_DAT: begin
                if (!cmd_busy) begin
                    state_d = WAIT_RSP;
                    tmo_d   = TMO_LOAD;
                end
            end
            WAIT_RSP: begin
                // A response in the last counted cycle still beats the timeout.
                if (rsp_stb) begin
                    done_fire = 1'b1;
                    done_data = rsp_word[31:0];
                    done_err  = (rsp_word[33:32] != 2'b00);
                end else if (tmo_q <= 8'd1) begin
                    done_fire = 1'b1;
                    done_err  = 1'b1;
                    tmo_d     = 8'd0;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_fire) begin
            state_d = DONE;
            if (gnt_if_q) begin
                if_rdata_d = done_data;
                if_err_d   = done_err;
                if_ack_d   = 1'b1;
            end else begin
                d_rdata_d = done_data;
                d_err_d   = done_err;
                d_ack_d   = 1'b1;
            end
        end

        // Command outputs follow the next state so they are registered and stay put under stall.
        cmd_stb_d  = 1'b0;
        cmd_word_d = 34'h0;
        case (state_d)
            RD_CMD: begin
                cmd_stb_d  = 1'b1;
                cmd_word_d = {2'b01, addr_d};
            end
            WR_ADR: begin
                cmd_stb_d  = 1'b1;
                cmd_word_d = {2'b10, addr_d};
            end
            WR_DAT: begin
                cmd_stb_d  = 1'b1;
                cmd_word_d = {2'b11, wdata_d};
            end
            default: begin
                cmd_stb_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            gnt_if_q   <= 1'b0;
            starve_q   <= '0;
            tmo_q      <= 8'd0;
            cmd_stb_q  <= 1'b0;
            cmd_word_q <= 34'h0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_if_q   <= gnt_if_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            cmd_stb_q  <= cmd_stb_d;
            cmd_word_q <= cmd_word_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_err_q   <= if_err_d;
            d_err_q    <= d_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign cmd_stb  = cmd_stb_q;
    assign cmd_word = cmd_word_q;
    assign if_ack   = if_ack_q;
    assign if_rdata = if_rdata_q;
    assign if_err   = if_err_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of arbitration, command sequences and completions.
module tb_mem_port_arbiter;
    localparam int TMO  = 8;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        cmd_stb, cmd_busy, rsp_stb;
    logic [33:0] cmd_word, rsp_word;

    mem_port_arbiter #(.TIMEOUT(TMO), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
        .rsp_stb(rsp_stb), .rsp_word(rsp_word)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    logic [33:0] exp_cmd[$];
    logic [33:0] acc_log[$];
    int          acc_edges[$];
    bit          m_free, m_skip, m_waiting, m_gnt_fetch, m_ack_due;
    int          m_starve, m_wait_cnt;
    logic [31:0] m_if_rdata, m_d_rdata;
    logic        m_if_err, m_d_err;
    int          edge_no = 0, acc_edge = 0, n_acks = 0;
    bit          last_hold_busy = 1'b0;
    logic [33:0] last_word = 34'h0;
    bit          saw_if_ack = 1'b0, saw_d_ack = 1'b0;
    // Responder: 0 = random delay/word, 1 = fixed delay/word, 2 = never respond
    int          rsp_mode = 0, rsp_delay = 0, rsp_fixed_delay = 0;
    logic [33:0] rsp_fixed = 34'h0;

    task automatic model_reset();
        exp_cmd.delete();
        m_free = 1'b1; m_skip = 1'b0; m_waiting = 1'b0; m_ack_due = 1'b0;
        m_starve = 0; m_wait_cnt = 0;
        m_if_rdata = 32'h0; m_d_rdata = 32'h0; m_if_err = 1'b0; m_d_err = 1'b0;
        last_hold_busy = 1'b0;
        rsp_stb = 1'b0; rsp_word = 34'h0;
    endtask

    task automatic set_result(input logic [31:0] data, input logic err);
        m_waiting = 1'b0;
        m_ack_due = 1'b1;
        if (m_gnt_fetch) begin m_if_rdata = data; m_if_err = err; end
        else begin m_d_rdata = data; m_d_err = err; end
    endtask

    // One clock: capture the inputs/outputs the edge sees, advance, then update the model and compare.
    task automatic tick();
        logic        p_reset, p_if, p_d, p_we, p_stb, p_busy, p_rsp;
        logic [31:0] p_ia, p_da, p_dw;
        logic [33:0] p_word, p_rw;
        logic [1:0]  code;
        bit          fw;
        p_reset = reset; p_if = if_req; p_d = d_req; p_we = d_we;
        p_stb = cmd_stb; p_busy = cmd_busy; p_rsp = rsp_stb;
        p_ia = if_addr; p_da = d_addr; p_dw = d_wdata; p_word = cmd_word; p_rw = rsp_word;
        @(posedge clk);
        #1;
        edge_no++;
        m_ack_due = 1'b0;
        if (p_reset) begin
            model_reset();
            check("rst_cmd_stb", cmd_stb, 0);
            check("rst_cmd_word", cmd_word, 0);
            check("rst_if_ack", if_ack, 0);
            check("rst_d_ack", d_ack, 0);
            check("rst_if_err", if_err, 0);
            check("rst_d_err", d_err, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            saw_if_ack = 1'b0; saw_d_ack = 1'b0;
            return;
        end
        if (last_hold_busy) begin
            check("stall_stb", p_stb, 1);
            check("stall_word", p_word, last_word);
        end
        last_hold_busy = p_stb && p_busy;
        last_word = p_word;
        if (m_waiting) begin
            if (p_rsp) set_result(p_rw[31:0], p_rw[33:32] != 2'b00);
            else begin
                m_wait_cnt++;
                if (m_wait_cnt == TMO) set_result(32'h0, 1'b1);
            end
        end
        if (p_stb && !p_busy) begin
            acc_log.push_back(p_word);
            acc_edges.push_back(edge_no);
            if (exp_cmd.size() == 0) check("cmd_unexp", p_word, 34'h0);
            else begin
                check("cmd_word", p_word, exp_cmd.pop_front());
                if (exp_cmd.size() == 0) begin
                    m_waiting = 1'b1; m_wait_cnt = 0; acc_edge = edge_no;
                    rsp_delay = (rsp_mode == 0) ? $urandom_range(0, TMO + 2) : rsp_fixed_delay;
                end else check("cmd_next_stb", cmd_stb, 1);
            end
        end
        if (m_skip) m_skip = 1'b0;
        else if (m_free) begin
            if (!p_if) m_starve = 0;
            if (p_if || p_d) begin
                fw = p_if && (!p_d || m_starve == SMAX);
                m_free = 1'b0;
                m_gnt_fetch = fw;
                if (fw) begin
                    m_starve = 0;
                    exp_cmd.push_back({2'b01, p_ia});
                end else begin
                    if (p_if) m_starve++;
                    if (p_we) begin
                        exp_cmd.push_back({2'b10, p_da});
                        exp_cmd.push_back({2'b11, p_dw});
                    end else exp_cmd.push_back({2'b01, p_da});
                end
                check("cmd_start", cmd_stb, 1);
            end
        end
        if (m_ack_due) begin m_free = 1'b1; m_skip = 1'b1; end
        check("if_ack", if_ack, m_ack_due && m_gnt_fetch);
        check("d_ack", d_ack, m_ack_due && !m_gnt_fetch);
        check("if_rdata", if_rdata, m_if_rdata);
        check("if_err", if_err, m_if_err);
        check("d_rdata", d_rdata, m_d_rdata);
        check("d_err", d_err, m_d_err);
        saw_if_ack = if_ack; saw_d_ack = d_ack;
        if (if_ack || d_ack) n_acks++;
        rsp_stb = 1'b0; rsp_word = 34'h0;
        if (m_waiting && rsp_mode != 2 && m_wait_cnt == rsp_delay) begin
            rsp_stb = 1'b1;
            code = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
            rsp_word = (rsp_mode == 1) ? rsp_fixed : {code, 32'($urandom)};
        end else if (rsp_mode == 0 && !m_waiting && $urandom_range(0, 9) == 0) begin
            rsp_stb = 1'b1;
            rsp_word = {2'b00, 32'($urandom)};
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        tick();
        while (!(saw_if_ack || saw_d_ack) && n < 60) begin
            tick();
            n++;
        end
        check(tag, saw_if_ack || saw_d_ack, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; cmd_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_random();
        if (saw_if_ack) if_req = 1'b0;
        if (saw_d_ack) d_req = 1'b0;
        if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
        end
        if (!d_req && $urandom_range(0, 3) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        end
        cmd_busy = ($urandom_range(0, 3) == 0);
    endtask

    int          start;
    logic [5:0]  ord;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; cmd_busy = 1'b0; rsp_stb = 1'b0; rsp_word = 34'h0;
        model_reset();
        do_reset();

        // Fetch read with immediate reply: ack in the 4th cycle counting the request cycle
        rsp_mode = 1; rsp_fixed_delay = 0; rsp_fixed = {2'b00, 32'hDEADBEEF};
        acc_log.delete(); acc_edges.delete();
        if_req = 1'b1; if_addr = 32'h0000_0010; start = edge_no;
        wait_ack("fetch_ack_seen");
        if_req = 1'b0;
        check("fetch_cmd", acc_log[0], {2'b01, 32'h0000_0010});
        check("fetch_latency", edge_no - start + 1, 4);
        check("fetch_rdata", if_rdata, 32'hDEADBEEF);
        check("fetch_err", if_err, 0);
        tick();
        check("fetch_ack_pulse", if_ack, 0);

        // Data write: two consecutive commands, ack in the 5th cycle
        acc_log.delete(); acc_edges.delete();
        rsp_fixed = {2'b00, 32'h1234_0000};
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55; start = edge_no;
        wait_ack("wr_ack_seen");
        d_req = 1'b0;
        check("wr_cmd_adr", acc_log[0], {2'b10, 32'h100});
        check("wr_cmd_dat", acc_log[1], {2'b11, 32'h55});
        check("wr_consec", acc_edges[1] - acc_edges[0], 1);
        check("wr_latency", edge_no - start + 1, 5);
        check("wr_d_ack", d_ack, 1);
        tick();

        // Backpressure on the address command
        acc_log.delete(); acc_edges.delete();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hAA;
        tick();
        cmd_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_stb", cmd_stb, 1);
            check("bp_word", cmd_word, {2'b10, 32'h200});
        end
        cmd_busy = 1'b0;
        wait_ack("bp_ack_seen");
        d_req = 1'b0;
        check("bp_accepts", acc_log.size(), 2);
        tick();

        // Starvation with both requests held
        do_reset();
        acc_log.delete(); acc_edges.delete();
        if_req = 1'b1; if_addr = 32'hF000_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hD000_0000;
        for (int k = 0; k < 6; k++) wait_ack("starve_ack_seen");
        if_req = 1'b0; d_req = 1'b0;
        ord = 6'b0;
        for (int k = 0; k < 6 && k < acc_log.size(); k++)
            ord = {ord[4:0], acc_log[k][31:28] == 4'hF};
        check("starve_order", ord, 6'b000010);
        tick();

        // Timeout with a late response afterwards
        do_reset();
        rsp_mode = 2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h77;
        wait_ack("tmo_ack_seen");
        d_req = 1'b0;
        check("tmo_gap", edge_no - acc_edge + 1, 9);
        check("tmo_err", d_err, 1);
        check("tmo_rdata", d_rdata, 0);
        rsp_stb = 1'b1; rsp_word = {2'b00, 32'h1234_5678};
        tick();
        rsp_stb = 1'b1; rsp_word = {2'b00, 32'h1234_5678};
        tick();
        check("late_d_ack", d_ack, 0);
        check("late_d_err", d_err, 1);
        check("late_d_rdata", d_rdata, 0);

        // Reset while waiting for a response, then a fresh fetch
        if_req = 1'b1; if_addr = 32'h40;
        start = 0;
        while (!m_waiting && start < 20) begin tick(); start++; end
        check("rstw_reached_wait", m_waiting, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; if_req = 1'b0;
        rsp_stb = 1'b1; rsp_word = {2'b00, 32'h0BAD_0BAD};
        tick();
        check("rstw_no_ack", if_ack, 0);
        rsp_mode = 1; rsp_fixed_delay = 1; rsp_fixed = {2'b00, 32'hCAFE_F00D};
        if_req = 1'b1; if_addr = 32'h44;
        wait_ack("rstw_fresh_ack");
        if_req = 1'b0;
        check("rstw_fresh_rdata", if_rdata, 32'hCAFE_F00D);
        check("rstw_fresh_err", if_err, 0);
        tick();

        // Random traffic against the model
        do_reset();
        rsp_mode = 0;
        n_acks = 0;
        start = 0;
        while (n_acks < 200 && start < 20000) begin
            drive_random();
            tick();
            start++;
        end
        check("rand_progress", n_acks >= 200, 1);
        if_req = 1'b0; d_req = 1'b0; cmd_busy = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
